// File: rtl/hope_display60.sv
// hope_display60: four-digit multiplexed common-anode 7-segment driver.
// Digits 1:0 show the running 0-59 count, digits 3:2 show the preset.
// Adds leading-zero blanking, a pause blink on the running digits and a
// decimal-point flash after each tens wrap of the timer.
module hope_display60 #(
   parameter int SCAN_DIV    = 1000,
   parameter int BLINK_TICKS = 256,
   parameter int DP_TICKS    = 512,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic [7:0] Count60,
   input  logic [7:0] Init_value60,
   input  logic [1:0] carry60,
   input  logic       blink_en,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int DW = $clog2(DP_TICKS + 1);

   localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [DW-1:0] DP_LOAD    = DW'(DP_TICKS);

   logic [PW-1:0] prescaler;
   logic [1:0]    sel;
   logic [15:0]   snapshot;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   logic [DW-1:0] dp_cnt;
   logic          carry_s1;
   logic          carry_s2;
   logic          carry_s3;

   logic          tick;
   logic          carry_edge;
   logic [PW-1:0] prescaler_n;
   logic [1:0]    sel_n;
   logic [15:0]   snap_n;
   logic [BW-1:0] blink_cnt_n;
   logic          blink_phase_n;
   logic [DW-1:0] dp_cnt_n;

   logic [3:0]    nibble;
   logic          blank;
   logic [3:0]    an_n;
   logic [6:0]    seg_n;
   logic          dp_n;

   // Only the tens-wrap carry drives the flash; the units carry is ignored.
   logic          unused_carry0;
   assign unused_carry0 = carry60[0];

   // Next-state for scan timing, frame snapshot, blink phase and DP timer.
   // The outputs are decoded from these next values so they change together
   // with sel, one cycle after the tick.
   always_comb begin
      tick          = (prescaler == PRE_LAST);
      carry_edge    = carry_s2 & ~carry_s3;
      prescaler_n   = tick ? '0 : prescaler + PW'(1);
      sel_n         = tick ? sel + 2'd1 : sel;
      snap_n        = (tick && sel == 2'd3) ? {Init_value60, Count60} : snapshot;
      blink_cnt_n   = blink_cnt;
      blink_phase_n = blink_phase;
      dp_cnt_n      = dp_cnt;
      if (!blink_en) begin
         blink_cnt_n   = '0;
         blink_phase_n = 1'b0;
      end else if (tick) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt_n   = '0;
            blink_phase_n = ~blink_phase;
         end else begin
            blink_cnt_n = blink_cnt + BW'(1);
         end
      end
      if (carry_edge) begin
         dp_cnt_n = DP_LOAD;
      end else if (tick && dp_cnt != '0) begin
         dp_cnt_n = dp_cnt - DW'(1);
      end
   end

   // Decode the slot that will be shown next: segment pattern, digit enable
   // with blanking, and the decimal point on the count tens digit.
   always_comb begin
      nibble = snap_n[{sel_n, 2'b00} +: 4];
      case (nibble)
         4'd0:    seg_n = 7'b1000000;
         4'd1:    seg_n = 7'b1111001;
         4'd2:    seg_n = 7'b0100100;
         4'd3:    seg_n = 7'b0110000;
         4'd4:    seg_n = 7'b0011001;
         4'd5:    seg_n = 7'b0010010;
         4'd6:    seg_n = 7'b0000010;
         4'd7:    seg_n = 7'b1111000;
         4'd8:    seg_n = 7'b0000000;
         4'd9:    seg_n = 7'b0010000;
         default: seg_n = 7'b0111111;
      endcase
      blank = (BLANK_LZ && sel_n[0] && nibble == 4'd0) ||
              (blink_en && blink_phase_n && !sel_n[1]);
      an_n  = blank ? 4'b1111 : ~(4'b0001 << sel_n);
      dp_n  = !((sel_n == 2'd1) && (dp_cnt_n != '0) && !blank);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (reset) begin
         prescaler   <= '0;
         sel         <= 2'd0;
         snapshot    <= 16'h0000;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         dp_cnt      <= '0;
         carry_s1    <= 1'b0;
         carry_s2    <= 1'b0;
         carry_s3    <= 1'b0;
         an          <= 4'b1111;
         seg         <= 7'b1111111;
         dp          <= 1'b1;
      end else begin
         prescaler   <= prescaler_n;
         sel         <= sel_n;
         snapshot    <= snap_n;
         blink_cnt   <= blink_cnt_n;
         blink_phase <= blink_phase_n;
         dp_cnt      <= dp_cnt_n;
         carry_s1    <= carry60[1];
         carry_s2    <= carry_s1;
         carry_s3    <= carry_s2;
         an          <= an_n;
         seg         <= seg_n;
         dp          <= dp_n;
      end
   end

endmodule

// File: tb/tb_hope_display60.sv
// Bench for hope_display60 with SCAN_DIV=4, BLINK_TICKS=8, DP_TICKS=4.
// After a reset release, cycle k shows slot (k/4)%4; a frame is 16 cycles.
module tb_hope_display60;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_D = 7'b0111111;
   localparam logic [6:0] SEG_X = 7'b1111111;

   logic       Clk;
   logic       reset;
   logic [7:0] Count60;
   logic [7:0] Init_value60;
   logic [1:0] carry60;
   logic       blink_en;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       chk_seg;
      string      name;
   } exp_t;

   typedef struct {
      logic [7:0]      count;
      logic [7:0]      init;
      logic [3:0][3:0] an;
      logic [3:0][6:0] seg;
   } vec_t;

   exp_t sbq[$];
   vec_t vecs[6];
   int   cyc;
   int   base;
   int   f;
   int   n_frm;
   int   g_frm;
   int   h_frm;
   int   tests_run;
   int   failures;

   hope_display60 #(
      .SCAN_DIV(4),
      .BLINK_TICKS(8),
      .DP_TICKS(4),
      .BLANK_LZ(1'b1)
   ) dut (
      .Clk(Clk),
      .reset(reset),
      .Count60(Count60),
      .Init_value60(Init_value60),
      .carry60(carry60),
      .blink_en(blink_en),
      .an(an),
      .seg(seg),
      .dp(dp)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Hard stop in case the sequence never completes.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: run did not finish, required finish before 200000");
      $fatal(1, "[TB] timeout");
   end

   task automatic push_exp(input int c, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp, input logic e_chk, input string nm);
      exp_t e;
      e.cyc     = c;
      e.an      = e_an;
      e.seg     = e_seg;
      e.dp      = e_dp;
      e.chk_seg = e_chk;
      e.name    = nm;
      sbq.push_back(e);
   endtask

   // Segment value is only compared on lit slots.
   task automatic exp_slot(input int c, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp, input string nm);
      push_exp(c, e_an, e_seg, e_dp, e_an != 4'b1111, nm);
   endtask

   task automatic checkOutput();
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].cyc == cyc) begin
            tests_run++;
            if (an !== sbq[i].an || dp !== sbq[i].dp ||
                (sbq[i].chk_seg && seg !== sbq[i].seg)) begin
               failures++;
               $display("[TB] FAIL %s @cycle %0d: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                        sbq[i].name, cyc - base, an, seg, dp, sbq[i].an, sbq[i].seg, sbq[i].dp);
            end
            sbq.delete(i);
         end
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
      cyc++;
      checkOutput();
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic applyStimulus(input logic [7:0] cnt, input logic [7:0] init);
      Count60      = cnt;
      Init_value60 = init;
   endtask

   initial begin
      vecs[0] = '{8'h05, 8'h00, {4'b1111, 4'b1011, 4'b1111, 4'b1110}, {SEG_X, SEG_0, SEG_X, SEG_5}};
      vecs[1] = '{8'h3C, 8'h59, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {SEG_5, SEG_9, SEG_3, SEG_D}};
      vecs[2] = '{8'hA0, 8'h59, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {SEG_5, SEG_9, SEG_D, SEG_0}};
      vecs[3] = '{8'h12, 8'h40, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {SEG_4, SEG_0, SEG_1, SEG_2}};
      vecs[4] = '{8'h86, 8'hF0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {SEG_D, SEG_0, SEG_8, SEG_6}};
      vecs[5] = '{8'h99, 8'h09, {4'b1111, 4'b1011, 4'b1101, 4'b1110}, {SEG_X, SEG_9, SEG_9, SEG_9}};

      tests_run = 0;
      failures  = 0;
      cyc       = 0;
      base      = 0;
      reset     = 1'b1;
      carry60   = 2'b00;
      blink_en  = 1'b0;
      applyStimulus(8'h37, 8'h59);
      repeat (3) step();
      reset = 1'b0;
      base  = cyc;

      // Reset values, then the all-zero first frame and slot timing.
      push_exp(base, 4'b1111, SEG_X, 1'b1, 1'b1, "reset_state");
      checkOutput();
      exp_slot(base + 1,  4'b1110, SEG_0, 1'b1, "f0_slot0_first");
      exp_slot(base + 3,  4'b1110, SEG_0, 1'b1, "f0_slot0_last");
      exp_slot(base + 4,  4'b1111, SEG_0, 1'b1, "f0_slot1_blank_start");
      exp_slot(base + 7,  4'b1111, SEG_0, 1'b1, "f0_slot1_blank_end");
      exp_slot(base + 8,  4'b1011, SEG_0, 1'b1, "f0_slot2_first");
      exp_slot(base + 14, 4'b1111, SEG_0, 1'b1, "f0_slot3_blank");
      exp_slot(base + 16, 4'b1110, SEG_7, 1'b1, "f1_slot0");
      exp_slot(base + 20, 4'b1101, SEG_3, 1'b1, "f1_slot1");
      exp_slot(base + 24, 4'b1011, SEG_9, 1'b1, "f1_slot2");
      exp_slot(base + 28, 4'b0111, SEG_5, 1'b1, "f1_slot3");
      run_to(base + 31);

      // Table of steady-state frames.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].count, vecs[i].init);
         f = base + ((cyc - base) / 16 + 1) * 16;
         for (int s = 0; s < 4; s++)
            exp_slot(f + 4 * s + 2, vecs[i].an[s], vecs[i].seg[s], 1'b1,
                     $sformatf("vec%0d_slot%0d", i, s));
         run_to(f + 15);
      end

      // Count change during slot 1 stays hidden until the next frame.
      applyStimulus(8'h12, 8'h40);
      n_frm = f + 16;
      run_to(n_frm + 5);
      applyStimulus(8'h34, 8'h40);
      exp_slot(n_frm + 6,  4'b1101, SEG_1, 1'b1, "midframe_old_tens");
      exp_slot(n_frm + 14, 4'b0111, SEG_4, 1'b1, "midframe_preset");
      exp_slot(n_frm + 16, 4'b1110, SEG_4, 1'b1, "midframe_new_units");
      exp_slot(n_frm + 20, 4'b1101, SEG_3, 1'b1, "midframe_new_tens");
      run_to(n_frm + 20);
      applyStimulus(8'h12, 8'h40);
      run_to(n_frm + 31);

      // Single carry pulse: DP lit on slot 1 for one window.
      g_frm = n_frm + 32;
      carry60 = 2'b10;
      exp_slot(g_frm + 3,  4'b1110, SEG_2, 1'b1, "dp1_slot0_off");
      exp_slot(g_frm + 5,  4'b1101, SEG_1, 1'b0, "dp1_slot1_on");
      exp_slot(g_frm + 7,  4'b1101, SEG_1, 1'b0, "dp1_slot1_on_end");
      exp_slot(g_frm + 8,  4'b1011, SEG_0, 1'b1, "dp1_slot2_off");
      exp_slot(g_frm + 21, 4'b1101, SEG_1, 1'b1, "dp1_expired");
      run_to(g_frm + 3);
      carry60 = 2'b00;
      run_to(g_frm + 31);

      // Pulse, then a retrigger landing on a tick: the reload wins.
      g_frm = g_frm + 32;
      run_to(g_frm + 8);
      carry60 = 2'b10;
      exp_slot(g_frm + 13, 4'b0111, SEG_4, 1'b1, "dp2_slot3_off");
      exp_slot(g_frm + 21, 4'b1101, SEG_1, 1'b0, "dp2_first_window");
      exp_slot(g_frm + 23, 4'b1101, SEG_1, 1'b0, "dp2_first_window_end");
      exp_slot(g_frm + 24, 4'b1011, SEG_0, 1'b1, "dp2_slot2_off");
      exp_slot(g_frm + 37, 4'b1101, SEG_1, 1'b0, "dp2_retrigger_extends");
      exp_slot(g_frm + 39, 4'b1101, SEG_1, 1'b0, "dp2_retrigger_extends_end");
      exp_slot(g_frm + 53, 4'b1101, SEG_1, 1'b1, "dp2_expired");
      run_to(g_frm + 11);
      carry60 = 2'b00;
      run_to(g_frm + 21);
      carry60 = 2'b10;
      run_to(g_frm + 24);
      carry60 = 2'b00;
      run_to(g_frm + 55);

      // Blink: 8 ticks visible, 8 blank on slots 0/1, preset always lit.
      h_frm = g_frm + 64;
      run_to(h_frm);
      blink_en = 1'b1;
      exp_slot(h_frm + 17, 4'b1110, SEG_2, 1'b1, "blink_visible_slot0");
      exp_slot(h_frm + 31, 4'b0111, SEG_4, 1'b1, "blink_visible_slot3");
      exp_slot(h_frm + 32, 4'b1111, SEG_2, 1'b1, "blink_blank_slot0");
      exp_slot(h_frm + 37, 4'b1111, SEG_1, 1'b1, "blink_blank_slot1");
      exp_slot(h_frm + 42, 4'b1011, SEG_0, 1'b1, "blink_slot2_lit");
      exp_slot(h_frm + 46, 4'b0111, SEG_4, 1'b1, "blink_slot3_lit");
      exp_slot(h_frm + 63, 4'b0111, SEG_4, 1'b1, "blink_slot3_last");
      exp_slot(h_frm + 64, 4'b1110, SEG_2, 1'b1, "blink_visible_again0");
      exp_slot(h_frm + 69, 4'b1101, SEG_1, 1'b1, "blink_visible_again1");
      exp_slot(h_frm + 98, 4'b1111, SEG_2, 1'b1, "blink_blank_before_reset");
      run_to(h_frm + 98);

      // Reset in the middle of a blank blink phase.
      reset = 1'b1;
      push_exp(h_frm + 99, 4'b1111, SEG_X, 1'b1, 1'b1, "midblink_reset");
      step();
      reset = 1'b0;
      base  = cyc;
      exp_slot(base + 2,  4'b1110, SEG_0, 1'b1, "post_reset_snapshot_zero");
      exp_slot(base + 3,  4'b1110, SEG_0, 1'b1, "post_reset_no_early_tick");
      exp_slot(base + 4,  4'b1111, SEG_0, 1'b1, "post_reset_first_tick");
      exp_slot(base + 16, 4'b1110, SEG_2, 1'b1, "post_reset_blink_visible0");
      exp_slot(base + 21, 4'b1101, SEG_1, 1'b1, "post_reset_blink_visible1");
      run_to(base + 22);

      while (sbq.size() > 0) begin
         tests_run++;
         failures++;
         $display("[TB] FAIL %s: check at cycle %0d never reached, required an=%b",
                  sbq[0].name, sbq[0].cyc, sbq[0].an);
         void'(sbq.pop_front());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
